// File: rtl/fetch.sv
// Instruction fetch stage: sequential PC generation, credit-limited imem requests,
// in-order response queue feeding decode. Optional same-cycle bypass: FETCH_BYPASS_EN.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_ex,
    input  logic [31:0] redirect_pc_ex,
    input  logic        stall_de0,
    output logic        imem_req_vld,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_rdy,
    input  logic        imem_rsp_vld,
    input  logic [31:0] imem_rsp_data,
    output logic        valid_de0,
    output logic [31:0] instr_de0,
    output logic [31:0] pc_de0
);
    localparam int AW = $clog2(FQ_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fq_entry_t;

    logic [31:0]   pc_q;
    logic [CW-1:0] out_q, squash_q, occ_q;
    logic [31:0]   pcf_mem [FQ_DEPTH];
    logic [AW-1:0] pcf_wr, pcf_rd;
    fq_entry_t     fq_mem [FQ_DEPTH];
    logic [AW-1:0] fq_wr, fq_rd;

    logic          req_fire, rsp_squash, rsp_live, fq_empty, fq_push, fq_pop, bypass;
    logic [CW+1:0] credit_used;
    logic [31:0]   rsp_pc;
    fq_entry_t     fq_head;

    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc_ex[1:0];

    always_comb begin
        credit_used   = {2'b00, out_q} + {2'b00, squash_q} + {2'b00, occ_q};
        imem_req_vld  = !reset && !redirect_ex && (credit_used < (CW+2)'(FQ_DEPTH));
        imem_req_addr = pc_q;
        req_fire      = imem_req_vld && imem_req_rdy;

        rsp_pc     = pcf_mem[pcf_rd];
        rsp_squash = imem_rsp_vld && (squash_q != '0);
        rsp_live   = imem_rsp_vld && (squash_q == '0);
        fq_empty   = (occ_q == '0);
        fq_head    = fq_mem[fq_rd];

`ifdef FETCH_BYPASS_EN
        // Empty queue and decode ready: hand the response straight through.
        bypass = !reset && !redirect_ex && rsp_live && fq_empty && !stall_de0;
`else
        bypass = 1'b0;
`endif
        fq_pop  = !reset && !redirect_ex && !fq_empty && !stall_de0;
        fq_push = !reset && !redirect_ex && rsp_live && !bypass;

        valid_de0 = fq_pop || bypass;
        instr_de0 = '0;
        pc_de0    = '0;
        if (!reset && !fq_empty) begin
            instr_de0 = fq_head.instr;
            pc_de0    = fq_head.pc;
        end else if (bypass) begin
            instr_de0 = imem_rsp_data;
            pc_de0    = rsp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            out_q    <= '0;
            squash_q <= '0;
            occ_q    <= '0;
            pcf_wr   <= '0;
            pcf_rd   <= '0;
            fq_wr    <= '0;
            fq_rd    <= '0;
        end else begin
            if (redirect_ex)
                pc_q <= {redirect_pc_ex[31:2], 2'b00};
            else if (req_fire)
                pc_q <= pc_q + 32'd4;

            // PC FIFO tracks every in-flight request, squashed or not.
            if (req_fire)
                pcf_wr <= pcf_wr + AW'(1);
            if (imem_rsp_vld)
                pcf_rd <= pcf_rd + AW'(1);

            if (redirect_ex) begin
                squash_q <= squash_q - CW'(rsp_squash) + out_q - CW'(rsp_live);
                out_q    <= '0;
                occ_q    <= '0;
                fq_rd    <= fq_wr;
            end else begin
                squash_q <= squash_q - CW'(rsp_squash);
                out_q    <= out_q + CW'(req_fire) - CW'(rsp_live);
                occ_q    <= occ_q + CW'(fq_push) - CW'(fq_pop);
                if (fq_push)
                    fq_wr <= fq_wr + AW'(1);
                if (fq_pop)
                    fq_rd <= fq_rd + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            pcf_mem[pcf_wr] <= pc_q;
        if (fq_push)
            fq_mem[fq_wr] <= '{instr: imem_rsp_data, pc: rsp_pc};
    end

    rsp_has_request: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_vld |-> (out_q != '0 || squash_q != '0));

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction fetch stage directly upstream of decode.
- Generates sequential PCs and issues word requests to the instruction memory port.
- Buffers in-order responses in a small fetch queue and presents one instruction per cycle on the DE0 interface (valid_de0 / instr_de0).
- Handles branch redirects from execute, including squashing of in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FQ_DEPTH, 4, fetch-queue entries; also the cap on outstanding requests plus queued entries (power of 2, >=2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- redirect_ex  in  1  branch/jump redirect valid.
- redirect_pc_ex  in  32  redirect target; bits [1:0] ignored, treated as 0.
- stall_de0  in  1  decode cannot accept this cycle.
- imem_req_vld  out  1  fetch request valid.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_req_rdy  in  1  memory accepts request.
- imem_rsp_vld  in  1  response valid; in order, latency >=1 cycle.
- imem_rsp_data  in  32  instruction word.
- valid_de0  out  1  instruction valid to decode.
- instr_de0  out  32  t_rv_instr to decode.
- pc_de0  out  32  PC of instr_de0.

Behaviour:
- Reset:
  - pc_q=RESET_PC; queue empty.
  - Outstanding count=0; squash count=0.
  - imem_req_vld=0, valid_de0=0, instr_de0=0, pc_de0=0.
  - Reset wins over all other inputs in the same cycle.
- Request issue:
  - imem_req_vld=1 when !reset && !redirect_ex && (outstanding + squash + occupancy) < FQ_DEPTH.
  - imem_req_addr=pc_q.
  - Handshake fires on imem_req_vld && imem_req_rdy: pc_q += 4 (wraps at 2^32), outstanding++.
  - Request must stay stable while not accepted.
- PC FIFO: each accepted request pushes its address into a depth-FQ_DEPTH PC FIFO, used to tag responses.
- Response handling, on imem_rsp_vld:
  - If squash>0: squash--, response dropped, its PC popped.
  - Else: write {data, PC} into the fetch queue, outstanding--.
  - Credit check guarantees the queue never overflows. A response arriving with no request in flight (outstanding=0, squash=0) is an assertion failure.
- Output:
  - valid_de0 = queue non-empty && !stall_de0.
  - instr_de0 / pc_de0 = queue head, combinational from the head.
  - Pop when valid_de0 is high.
  - Same-cycle push and pop is legal and occupancy is unchanged.
  - Empty queue gives valid_de0=0 with zero-latency bypass (see Optional Feature).
- Latency: in the zero-wait case, imem_rsp_vld cycle N gives valid_de0 in cycle N+1.
- Redirect, redirect_ex=1 in cycle N:
  - Queue flushed.
  - squash += outstanding (excluding any response consumed in N), outstanding=0.
  - pc_q=redirect_pc_ex.
  - No request issued in N; valid_de0=0 in N.
  - First request to the target goes out in N+1.
  - A response arriving in N is dropped.
- Redirect during stall: the flush still happens.

Optional Feature:
- FETCH_BYPASS_EN:
  - When defined: if the queue is empty, stall_de0=0 and a non-squashed response arrives, it drives valid_de0/instr_de0/pc_de0 in the same cycle without being enqueued.
  - Minimum latency becomes 0 cycles from response.
  - When undefined: every response goes through the queue (1-cycle latency).

Test Plan:
- Reset release, RESET_PC=0x100, rdy=1, 1-cycle memory: requests 0x100, 0x104, 0x108…; first valid_de0 with pc_de0=0x100 two cycles after the first request (one with FETCH_BYPASS_EN).
- stall_de0 held high for 10 cycles: requests stop after FQ_DEPTH=4 are credited; no instruction lost or duplicated; order is 0x100..0x10C after release.
- redirect_ex to 0x2000 with 2 responses in flight: both dropped; next valid_de0 has pc_de0=0x2000 and its data; no stale PC appears.
- imem_req_rdy toggled randomly: addresses strictly sequential; each address issued exactly once.
- PC wrap: redirect to 0xFFFF_FFFC gives next request 0x0000_0000.
- Reset asserted with queue full and 2 outstanding: next cycle all outputs are 0 and the first request after release is RESET_PC.
